// File: rtl/rw_reg_bank_shadow.sv
// Shadowed control-register bank.
// Writes land in a shadow copy of each register; the active copy, which drives
// the analog/power logic, only follows the shadow copy on a commit strobe.
// Bank writes need mode permission and a two-key unlock sequence. The unlock
// relocks on its own after a run of cycles with no accepted bank write.
// Reads are registered, with one cycle of latency.
module rw_reg_bank_shadow #(
    parameter int                      DW           = 8,
    parameter int                      AW           = 8,
    parameter int                      REG_NUM      = 4,
    parameter logic [AW-1:0]           BASE_ADDR    = '0,
    parameter logic [AW-1:0]           LOCK_ADDR    = {AW{1'b1}},
    parameter logic [REG_NUM*DW-1:0]   DEFAULT_VAL  = '0,
    parameter logic [REG_NUM-1:0]      TEST_WR_MASK = '1,
    parameter logic [REG_NUM-1:0]      TEST_RD_MASK = '1,
    parameter logic [REG_NUM-1:0]      CFG_WR_MASK  = '1,
    parameter logic [REG_NUM-1:0]      CFG_RD_MASK  = '1,
    parameter logic [DW-1:0]           KEY0         = DW'(8'h5A),
    parameter logic [DW-1:0]           KEY1         = DW'(8'hA5),
    parameter int                      UNLOCK_TO    = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wen,
    input  logic                  i_ren,
    input  logic                  i_test_mode_status,
    input  logic                  i_cfg_mode_status,
    input  logic [AW-1:0]         i_addr,
    input  logic [DW-1:0]         i_wdata,
    input  logic                  i_commit,
    output logic [DW-1:0]         o_rdata,
    output logic                  o_rvld,
    output logic                  o_wr_err,
    output logic                  o_unlocked,
    output logic [REG_NUM*DW-1:0] o_reg_odata
);

    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int CNT_W = (UNLOCK_TO > 1) ? $clog2(UNLOCK_TO + 1) : 1;

    // Offset is computed one bit wider than the address so that an address
    // below BASE_ADDR wraps to a huge value and can never look like a hit.
    localparam logic [AW:0]      REG_SPAN = (AW + 1)'(REG_NUM);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(UNLOCK_TO);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY_WAIT = 2'd1,
        UNLOCKED = 2'd2
    } lock_state_t;

    lock_state_t state;
    lock_state_t state_next;

    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_next;

    logic [DW-1:0] shadow [REG_NUM];
    logic [DW-1:0] active [REG_NUM];

    logic [AW:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             bank_hit;
    logic             lock_hit;
    logic             mode_any;
    logic             wr_perm;
    logic             rd_perm;
    logic             bank_wr;
    logic             bank_wr_ok;
    logic             bank_wr_bad;
    logic             lock_wr;
    logic             rd_bank;
    logic             rd_lock;
    logic             timeout;

    // Address decode and access qualification shared by all the processes below.
    always_comb begin
        offset      = {1'b0, i_addr} - {1'b0, BASE_ADDR};
        bank_hit    = (offset < REG_SPAN);
        idx         = offset[IDX_W-1:0];
        lock_hit    = (i_addr == LOCK_ADDR);
        mode_any    = i_test_mode_status | i_cfg_mode_status;

        wr_perm     = (i_test_mode_status & TEST_WR_MASK[idx])
                    | (i_cfg_mode_status  & CFG_WR_MASK[idx]);
        rd_perm     = (i_test_mode_status & TEST_RD_MASK[idx])
                    | (i_cfg_mode_status  & CFG_RD_MASK[idx]);

        bank_wr     = i_wen & bank_hit;
        bank_wr_ok  = bank_wr & wr_perm & (state == UNLOCKED);
        bank_wr_bad = bank_wr & ~bank_wr_ok;
        lock_wr     = i_wen & lock_hit & mode_any;

        rd_bank     = i_ren & bank_hit & rd_perm;
        rd_lock     = i_ren & lock_hit & mode_any;

        timeout     = (UNLOCK_TO != 0) && (state == UNLOCKED)
                   && (idle_cnt == CNT_ONE) && !bank_wr_ok;
    end

    // Lock state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= LOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Lock sequencing: KEY0 then KEY1 unlocks; anything out of order relocks.
    always_comb begin
        state_next = state;
        case (state)
            LOCKED: begin
                if (lock_wr && (i_wdata == KEY0)) begin
                    state_next = KEY_WAIT;
                end
            end
            KEY_WAIT: begin
                if (lock_wr) begin
                    state_next = (i_wdata == KEY1) ? UNLOCKED : LOCKED;
                end else if (bank_wr) begin
                    state_next = LOCKED;
                end
            end
            UNLOCKED: begin
                if (lock_wr || timeout) begin
                    state_next = LOCKED;
                end
            end
            default: state_next = LOCKED;
        endcase
    end

    // Lock status output, decoded from the state flop only.
    always_comb begin
        o_unlocked = (state == UNLOCKED);
    end

    // Inactivity counter: loaded on entry to UNLOCKED and on each accepted write.
    always_comb begin
        idle_cnt_next = idle_cnt;
        if ((UNLOCK_TO == 0) || (state_next != UNLOCKED)) begin
            idle_cnt_next = '0;
        end else if ((state != UNLOCKED) || bank_wr_ok) begin
            idle_cnt_next = CNT_LOAD;
        end else begin
            idle_cnt_next = idle_cnt - CNT_ONE;
        end
    end

    // Inactivity counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_next;
        end
    end

    // Shadow stage: takes accepted bank writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < REG_NUM; k++) begin
                shadow[k] <= DEFAULT_VAL[k*DW +: DW];
            end
        end else if (bank_wr_ok) begin
            shadow[idx] <= i_wdata;
        end
    end

    // Active stage: copies the pre-write shadow contents on commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < REG_NUM; k++) begin
                active[k] <= DEFAULT_VAL[k*DW +: DW];
            end
        end else if (i_commit) begin
            for (int k = 0; k < REG_NUM; k++) begin
                active[k] <= shadow[k];
            end
        end
    end

    // Flatten the active stage onto the output bus.
    always_comb begin
        o_reg_odata = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            o_reg_odata[k*DW +: DW] = active[k];
        end
    end

    // Registered read port; a read in the same cycle as a write sees the old value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rvld  <= 1'b0;
            o_rdata <= '0;
        end else begin
            o_rvld <= rd_bank | rd_lock;
            if (rd_bank) begin
                o_rdata <= shadow[idx];
            end else if (rd_lock) begin
                o_rdata <= DW'(state);
            end else begin
                o_rdata <= '0;
            end
        end
    end

    // One-cycle error pulse for a bank write that was turned away.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_err <= 1'b0;
        end else begin
            o_wr_err <= bank_wr_bad;
        end
    end

endmodule

// File: doc/rw_reg_bank_shadow.md
Name: rw_reg_bank_shadow

Overview:
- Parametrised bank of REG_NUM control registers at a contiguous address window.
- Each register has a shadow stage that takes writes and an active stage that drives the analog/power logic.
- Shadow-to-active transfer happens only on a commit strobe.
- Writes are gated by test/cfg mode masks and by a two-key unlock state machine with an inactivity timeout.
- Reads are registered.

Parameters:
DW, 8, data width
AW, 8, address width
REG_NUM, 4, number of registers in bank (>=1)
BASE_ADDR, 0, address of register 0
LOCK_ADDR, 8'hFF, lock/key register address; must lie outside [BASE_ADDR, BASE_ADDR+REG_NUM-1]
DEFAULT_VAL, all zeros (REG_NUM*DW bits), reset value; register k = bits [k*DW +: DW]
TEST_WR_MASK / TEST_RD_MASK / CFG_WR_MASK / CFG_RD_MASK, all ones (REG_NUM bits), per-register access permission in each mode
KEY0, 8'h5A, first unlock key (DW bits)
KEY1, 8'hA5, second unlock key (DW bits)
UNLOCK_TO, 64, cycles without an accepted write before auto-relock; 0 disables the timeout

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_wen  input  1  write strobe
i_ren  input  1  read strobe
i_test_mode_status  input  1  test mode active
i_cfg_mode_status  input  1  cfg mode active
i_addr  input  AW  access address
i_wdata  input  DW  write data
i_commit  input  1  copy all shadow registers to active
o_rdata  output  DW  read data, valid with o_rvld
o_rvld  output  1  read data valid
o_wr_err  output  1  one-cycle pulse: bank write rejected
o_unlocked  output  1  lock FSM in UNLOCKED
o_reg_odata  output  REG_NUM*DW  active register values

Behaviour:
- Reset (async, i_rst_n low): shadow = active = DEFAULT_VAL; FSM = LOCKED; timeout counter = 0; o_rdata = 0; o_rvld = 0; o_wr_err = 0.
- Bank hit: BASE_ADDR <= i_addr <= BASE_ADDR+REG_NUM-1; idx = i_addr - BASE_ADDR, computed without wrap past 2^AW.
- Mode permission for register k: (test & TEST_x_MASK[k]) | (cfg & CFG_x_MASK[k]).
- Lock register access requires test | cfg.
- Accepted bank write requires i_wen & hit & write permission & UNLOCKED. Effect: shadow[idx] <= i_wdata at the next edge; active is unchanged.
- Rejected bank write: i_wen & hit & (no permission | not UNLOCKED). Shadow is unchanged; o_wr_err = 1 in the next cycle only.
- Lock FSM, states LOCKED(0), KEY_WAIT(1), UNLOCKED(2); transitions happen only on a permitted write to LOCK_ADDR unless noted:
  - LOCKED: i_wdata==KEY0 -> KEY_WAIT; any other value -> stay LOCKED.
  - KEY_WAIT: i_wdata==KEY1 -> UNLOCKED; any other value -> LOCKED.
  - KEY_WAIT: any bank write, accepted or not, -> LOCKED.
  - UNLOCKED: any value -> LOCKED.
- Timeout: on entry to UNLOCKED the counter loads UNLOCK_TO. It reloads on each accepted bank write and otherwise decrements each cycle. When it reaches 1 with no write that cycle, FSM -> LOCKED next edge. A write to LOCK_ADDR in the same cycle takes priority.
- o_unlocked = (state == UNLOCKED), registered.
- Commit: i_commit high -> active[k] <= shadow[k] for all k at the next edge.
  - Simultaneous write and commit: active takes the pre-write shadow value; the new data stays in shadow only.
  - Commit is independent of the lock state and mode.
- Read, 1-cycle latency: accepted if i_ren & (bank hit & read permission, or LOCK_ADDR & (test|cfg)).
  - Next cycle: o_rvld = 1; o_rdata = shadow[idx], or for LOCK_ADDR zero-extended {state[1:0]}.
  - Not accepted: o_rvld = 0, o_rdata = 0.
  - Simultaneous read and write to the same register: read returns the pre-write value.
- o_reg_odata is registered and glitch-free; it changes only on commit or reset.
- Reset mid-unlock sequence or mid-timeout: returns to LOCKED, shadow and active revert to DEFAULT_VAL.

Test Plan:
- After reset, cfg=1, read addr 0 -> o_rvld=1, o_rdata=DEFAULT_VAL[7:0] one cycle later; o_reg_odata=DEFAULT_VAL; o_unlocked=0.
- LOCKED, write 8'h33 to addr 1 -> o_wr_err pulses one cycle; read addr 1 still returns default.
- Unlock: write 5A then A5 to FF, then write 8'h33 to addr 1 -> o_unlocked=1, read returns 33, o_reg_odata[15:8] unchanged. Pulse i_commit -> o_reg_odata[15:8]=33 next cycle.
- Write 8'h44 to addr 1 with i_commit in the same cycle -> active=33, shadow=44; a second commit gives active=44.
- Broken key: 5A, then a bank write, then A5 -> FSM LOCKED (read FF = 0), the write is rejected.
- Timeout with UNLOCK_TO=4: unlock, then idle 4 cycles -> o_unlocked falls. A write at cycle 3 extends the window by 4 more cycles.
- CFG_WR_MASK=4'b1110, cfg=1, test=0, unlocked: write addr 0 is rejected (o_wr_err), write addr 2 is accepted.
